// File: rtl/result_display_driver_if.sv
// ---------------------------------------------------------------------------
// result_display_driver_if
//   Bundles the processor-store side and the display side of the
//   result display driver.
//
//   Parameter:
//     DIGITS     number of displayed decimal digits (must match the driver)
//
//   Signals:
//     MemWrite   processor store strobe (high = RD2 is a result to show)
//     RD2        32-bit store data, unsigned
//     Busy       conversion in progress
//     Overflow   displayed value does not fit in DIGITS decimal digits
//     DispValue  binary value currently shown
//     AN         digit enables, active-low, one-hot-low
//     SEG        segments {g,f,e,d,c,b,a}, active-low
//
//   Modports:
//     master     processor/test side (drives MemWrite, RD2)
//     slave      result_display_driver side (drives everything else)
// ---------------------------------------------------------------------------
interface result_display_driver_if #(
  parameter int DIGITS = 4
);
  logic              MemWrite;
  logic [31:0]       RD2;
  logic              Busy;
  logic              Overflow;
  logic [31:0]       DispValue;
  logic [DIGITS-1:0] AN;
  logic [6:0]        SEG;

  modport master (
    output MemWrite,
    output RD2,
    input  Busy,
    input  Overflow,
    input  DispValue,
    input  AN,
    input  SEG
  );

  modport slave (
    input  MemWrite,
    input  RD2,
    output Busy,
    output Overflow,
    output DispValue,
    output AN,
    output SEG
  );
endinterface

// File: rtl/result_display_driver.sv
// ---------------------------------------------------------------------------
// result_display_driver
//   Captures the value stored by the processor (RD2 qualified by MemWrite),
//   converts it to BCD with a sequential double-dabble (one bit per clock)
//   and drives a time-multiplexed, active-low 7-segment display with it.
//   Values that do not fit in DIGITS decimal digits are shown as dashes.
//
//   Parameters:
//     DIGITS       displayed decimal digits (1..8), digit 0 = least significant
//     REFRESH_DIV  clocks each digit stays lit before the scan advances (>=2)
//
//   Ports:
//     CLK          system clock, all state on the rising edge
//     RST          asynchronous, active-high reset
//     bus          result_display_driver_if.slave
//                  (MemWrite, RD2 in; Busy, Overflow, DispValue, AN, SEG out)
//
//   Optional feature macro:
//     LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                            nonzero digit are blanked (digit 0 always shows).
// ---------------------------------------------------------------------------
module result_display_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input logic                    CLK,
  input logic                    RST,
  result_display_driver_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int NIBS  = 10;  // 10 BCD digits cover any 32-bit value

  localparam logic [DIGITS-1:0] AN_RST  = ~(DIGITS'(1));
  localparam logic [6:0]        SEG_DASH  = 7'b0111111;
  localparam logic [6:0]        SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Conversion datapath
  state_t              state_q, state_d;
  logic [31:0]         bin_q, bin_d;
  logic [39:0]         bcd_q, bcd_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [31:0]         src_q, src_d;
  logic [31:0]         pend_val_q, pend_val_d;
  logic                pend_vld_q, pend_vld_d;

  // Display state
  logic [DIGITS*4-1:0] digits_q, digits_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         disp_val_q, disp_val_d;

  // Scan state
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  // Combinational helpers
  logic [35:0]         bcd_adj;
  logic                bcd_high_nz;
  logic [3:0]          nib_sel;
  logic                blank_sel;
  logic [DIGITS-1:0]   blank_mask;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Double-dabble add-3 correction. The top nibble of a 32-bit value never
  // exceeds 4, so it never needs correcting and only nibbles 0..8 get adders.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NIBS - 1; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
    end
  endgenerate

  // Any nonzero BCD digit above the displayed range means overflow.
  always_comb begin
    bcd_high_nz = 1'b0;
    for (int i = 0; i < NIBS; i++) begin
      if (i >= DIGITS && bcd_q[i*4 +: 4] != 4'd0) begin
        bcd_high_nz = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Conversion FSM: next state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    bit_cnt_d  = bit_cnt_q;
    src_d      = src_q;
    pend_val_d = pend_val_q;
    pend_vld_d = pend_vld_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    disp_val_d = disp_val_q;

    case (state_q)
      IDLE: begin
        if (bus.MemWrite) begin
          bin_d     = bus.RD2;
          src_d     = bus.RD2;
          bcd_d     = '0;
          bit_cnt_d = '0;
          state_d   = CONVERT;
        end
      end

      CONVERT: begin
        bcd_d     = {bcd_q[38:36], bcd_adj, bin_q[31]};
        bin_d     = {bin_q[30:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          state_d = DONE;
        end
        // Writes during a conversion wait in the one-deep buffer; newest wins.
        if (bus.MemWrite) begin
          pend_val_d = bus.RD2;
          pend_vld_d = 1'b1;
        end
      end

      DONE: begin
        digits_d   = bcd_q[DIGITS*4-1:0];
        disp_val_d = src_q;
        ovf_d      = bcd_high_nz;
        // A fresh write beats the buffered value; either way the buffer
        // empties because a new conversion starts now.
        if (bus.MemWrite) begin
          bin_d      = bus.RD2;
          src_d      = bus.RD2;
          bcd_d      = '0;
          bit_cnt_d  = '0;
          pend_vld_d = 1'b0;
          state_d    = CONVERT;
        end else if (pend_vld_q) begin
          bin_d      = pend_val_q;
          src_d      = pend_val_q;
          bcd_d      = '0;
          bit_cnt_d  = '0;
          pend_vld_d = 1'b0;
          state_d    = CONVERT;
        end else begin
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Scan: refresh counter, digit index and registered AN/SEG. SEG is built
  // from the next index and next display contents so it always matches the
  // digit that AN enables, including on the cycle the display is updated.
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // blank_mask[i] is set when digit i lies above the most significant
  // nonzero digit; digit 0 is never blanked.
  always_comb begin
    blank_mask = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic upper_zero;
      upper_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (digits_d[i*4 +: 4] != 4'd0) begin
          upper_zero = 1'b0;
        end
        blank_mask[i] = upper_zero;
      end
    end
`endif
  end

  always_comb begin
    an_d      = '1;
    nib_sel   = '0;
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        an_d[i]   = 1'b0;
        nib_sel   = digits_d[i*4 +: 4];
        blank_sel = blank_mask[i];
      end
    end

    if (ovf_d) begin
      seg_d = SEG_DASH;
    end else if (blank_sel) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_decode(nib_sel);
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
      src_q      <= '0;
      pend_val_q <= '0;
      pend_vld_q <= 1'b0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
      disp_val_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      an_q       <= AN_RST;
      seg_q      <= 7'b1000000;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      bit_cnt_q  <= bit_cnt_d;
      src_q      <= src_d;
      pend_val_q <= pend_val_d;
      pend_vld_q <= pend_vld_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
      disp_val_q <= disp_val_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.Busy      = (state_q != IDLE);
  assign bus.Overflow  = ovf_q;
  assign bus.DispValue = disp_val_q;
  assign bus.AN        = an_q;
  assign bus.SEG       = seg_q;

endmodule

// File: tb/tb_result_display_driver.sv
// ---------------------------------------------------------------------------
// tb_result_display_driver
//   Scoreboard bench: every write expected to reach the display pushes its
//   value/overflow pair; a monitor pops and compares whenever DispValue
//   changes. Scan contents and dwell times are checked against a decimal
//   model of the expected digits.
// ---------------------------------------------------------------------------
module tb_result_display_driver;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  result_display_driver_if #(.DIGITS(DIGITS)) bus ();

  result_display_driver #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] val;
    logic        ovf;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks  = 0;
  int          n_errors  = 0;
  logic [31:0] last_disp = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [31:0] v, input int idx);
    longint d;
    if (longint'(v) >= pow10(DIGITS)) return 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && longint'(v) < pow10(idx)) return 7'b1111111;
`endif
    d = (longint'(v) / pow10(idx)) % 10;
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  task automatic sb_push(input logic [31:0] v);
    exp_t e;
    e.val = v;
    e.ovf = (longint'(v) >= pow10(DIGITS));
    sb_q.push_back(e);
  endtask

  // Monitor: each change of DispValue consumes one scoreboard entry.
  always @(negedge CLK) begin
    if (RST !== 1'b0) begin
      last_disp = '0;
    end else if (bus.DispValue !== last_disp) begin
      exp_t e;
      last_disp = bus.DispValue;
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_disp_value", bus.DispValue, e.val);
        check("sb_overflow", 32'(bus.Overflow), 32'(e.ovf));
      end
      $display("display update: DispValue=%0d Overflow=%0b at %0t", bus.DispValue, bus.Overflow, $time);
    end
  end

  // Called at a negedge: MemWrite is sampled at the next rising edge (N)
  // and the task returns at the negedge following edge N.
  task automatic drive_write(input logic [31:0] v);
    bus.MemWrite = 1'b1;
    bus.RD2      = v;
    @(negedge CLK);
    bus.MemWrite = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200 && bus.Busy !== 1'b0; c++) @(negedge CLK);
    check("idle_reached", 32'(bus.Busy), 32'd0);
  endtask

  // One full scan period: every digit must show the expected pattern and
  // stay lit for exactly REFRESH_DIV clocks.
  task automatic scan_check(input logic [31:0] v);
    int cnt[DIGITS];
    int idx;
    for (int i = 0; i < DIGITS; i++) cnt[i] = 0;
    for (int c = 0; c < DIGITS * REFRESH_DIV; c++) begin
      @(negedge CLK);
      idx = 0;
      for (int i = 0; i < DIGITS; i++) if (bus.AN[i] == 1'b0) idx = i;
      check("an_onehot_low", 32'($countones(~bus.AN)), 32'd1);
      check($sformatf("seg_digit%0d_val%0d", idx, v), 32'(bus.SEG), 32'(exp_seg(v, idx)));
      cnt[idx]++;
    end
    for (int i = 0; i < DIGITS; i++) check($sformatf("dwell_digit%0d", i), 32'(cnt[i]), 32'(REFRESH_DIV));
    $display("scan checked: value=%0d", v);
  endtask

  task automatic convert(input logic [31:0] v);
    sb_push(v);
    drive_write(v);
    wait_idle();
    scan_check(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST          = 1'b0;
    bus.MemWrite = 1'b0;
    bus.RD2      = '0;

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    #3 RST = 1'b1;
    #1;
    check("rst_an", 32'(bus.AN), 32'(4'b1110));
    check("rst_seg", 32'(bus.SEG), 32'(7'b1000000));
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_overflow", 32'(bus.Overflow), 32'd0);
    check("rst_dispvalue", bus.DispValue, 32'd0);
    $display("reset applied");
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // 1234 with exact latency
    sb_push(32'd1234);
    drive_write(32'd1234);
    check("lat_busy_start", 32'(bus.Busy), 32'd1);
    repeat (32) @(negedge CLK);
    check("lat_disp_pre", bus.DispValue, 32'd0);
    check("lat_busy_pre", 32'(bus.Busy), 32'd1);
    @(negedge CLK);
    check("lat_disp_post", bus.DispValue, 32'd1234);
    check("lat_ovf_post", 32'(bus.Overflow), 32'd0);
    check("lat_busy_post", 32'(bus.Busy), 32'd0);
    scan_check(32'd1234);

    // Overflow boundary
    convert(32'd10000);
    convert(32'd9999);

    // Pending buffer: 5, 6, 7 ten cycles apart; 6 is overwritten by 7.
    sb_push(32'd5);
    sb_push(32'd7);
    drive_write(32'd5);
    for (int k = 0; k <= 66; k++) begin
      check("pend_busy", 32'(bus.Busy), 32'(k <= 65));
      bus.MemWrite = (k == 9 || k == 19);
      bus.RD2      = (k == 9) ? 32'd6 : 32'd7;
      if (k < 66) @(negedge CLK);
    end
    bus.MemWrite = 1'b0;
    $display("pending sequence 5/6/7 done");
    scan_check(32'd7);

    // Reset in the middle of converting 42, with 99 buffered as pending.
    drive_write(32'd42);
    for (int k = 0; k < 15; k++) begin
      bus.MemWrite = (k == 4);
      bus.RD2      = 32'd99;
      @(negedge CLK);
    end
    bus.MemWrite = 1'b0;
    RST = 1'b1;
    #1;
    check("midrst_an", 32'(bus.AN), 32'(4'b1110));
    check("midrst_busy", 32'(bus.Busy), 32'd0);
    check("midrst_disp", bus.DispValue, 32'd0);
    $display("reset during conversion");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (60) @(negedge CLK);
    check("midrst_no_pending_busy", 32'(bus.Busy), 32'd0);
    check("midrst_disp_after", bus.DispValue, 32'd0);
    scan_check(32'd0);
    convert(32'd8);

    // Leading-zero cases (blanked only when the option is compiled in)
    convert(32'd7);
    convert(32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/result_display_driver.md
Name: result_display_driver

Overview:
- Downstream consumer of the single-cycle processor top. It captures the value the processor stores (RD2 qualified by MemWrite) and converts it from binary to BCD sequentially (double-dabble, one bit per clock).
- It drives a time-multiplexed, active-low 7-segment display showing the last calculator result.
- Display digits are dashes when the result does not fit in DIGITS decimal digits.

Parameters:
- DIGITS, 4, number of displayed decimal digits (1..8); digit 0 = least significant.
- REFRESH_DIV, 50000, clocks each digit stays lit before the scan advances (>=2).

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- MemWrite  in  1  processor store strobe; high = RD2 is a result to display.
- RD2  in  32  store data from processor, treated as unsigned.
- Busy  out  1  conversion in progress.
- Overflow  out  1  displayed value exceeds 10^DIGITS-1.
- DispValue  out  32  binary value currently shown.
- AN  out  DIGITS  digit enables, active-low, one-hot-low.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (async, immediate) values:
  - Busy=0, Overflow=0, DispValue=0.
  - Digit index=0, AN=~1 (only AN[0] low), SEG=7'b1000000 ("0").
  - Refresh counter=0, pending buffer empty.
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - MemWrite=1 loads RD2 into the shift register, clears the 40-bit BCD accumulator and bit counter=0, then goes to CONVERT.
- CONVERT:
  - Each cycle, every BCD nibble >=5 gets +3, then {bcd,bin} shifts left 1.
  - After 32 shifts (counter 31 reached), goes to DONE.
  - Busy=1 in CONVERT and DONE.
- DONE (1 cycle):
  - Copies the low DIGITS BCD nibbles to the display register and the source value to DispValue.
  - Overflow=1 if any BCD nibble above DIGITS-1 is nonzero.
  - Next state is CONVERT when a pending value exists or MemWrite=1; otherwise IDLE.
- Latency: MemWrite sampled at edge N leaves the display/DispValue/Overflow updated after edge N+33, and Busy low after edge N+33 when nothing is pending.
- Pending buffer (1 deep):
  - MemWrite=1 while in CONVERT or DONE stores RD2 as pending; a newer write overwrites it (newest wins).
  - A MemWrite in DONE takes priority over an existing pending value.
  - A conversion in progress is never aborted.
  - Pending is consumed when the next conversion starts.
- Overflow display: all digits show dash (7'b0111111); DispValue still holds the true value.
- Scan: refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, the digit index advances and wraps from DIGITS-1 to 0.
- AN and SEG update in the same cycle as the index (registered outputs). SEG always matches the active digit.
- Segment codes 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Scan runs continuously and is unaffected by conversions; the display register changes only in DONE.
- Reset mid-conversion: everything returns to reset values and pending is discarded.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: digits above the most significant nonzero digit show blank (7'b1111111). Digit 0 always shows, so value 0 shows "0". Overflow dashes are unaffected.
- Undefined: all digits show, including leading zeros.

Test Plan:
- Reset: assert RST mid-cycle -> AN immediately 4'b1110, SEG=1000000, Busy=0, Overflow=0, DispValue=0.
- MemWrite pulse, RD2=1234 -> Busy=1 the next cycle; after edge N+33 DispValue=1234, Overflow=0, Busy=0. Scan with REFRESH_DIV=4 shows digits 4,3,2,1 on AN[0..3], each for 4 clocks.
- RD2=10000 -> Overflow=1, all digits 0111111, DispValue=10000. Then RD2=9999 -> Overflow=0, digits 9999.
- Writes of 5, then 6, then 7 spaced 10 cycles apart starting at IDLE -> 5 displays, 6 is overwritten, 7 displays after the second conversion. Busy stays high continuously through both conversions.
- RST asserted at conversion cycle 15 of value 42 -> display stays 0000, pending empty, next write of 8 converts normally.
- LEADING_ZERO_BLANK_EN defined, RD2=7 -> digits 3..1 blank (1111111), digit 0 = 1111000. RD2=0 -> digit 0 = 1000000, others blank.
